spi_cfg_responder: RTL

- SPI mode-0 target (responder) oversampled by clk_dot4x. It implements the 25xx-style command subset that the vicii SPI master issues to its persistence EEPROM/flash: READ, WRITE, RDSR and WREN.
- The address space maps onto a synchronous byte-wide register/RAM port, so the same pins can be served by on-board logic for emulation and bench use.
- Sits opposite vicii's spi_d/spi_q/spi_c/eeprom_s pins. It is instantiated either in the bench top level or in a companion FPGA on the SPI bus.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_cfg_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared opcodes, FSM state encoding and status-register layout for the
// SPI configuration responder.
package spi_pkg;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
   localparam logic [7:0] SPI_CMD_RDSR  = 8'h05;
   localparam logic [7:0] SPI_CMD_WREN  = 8'h06;

   localparam int STAT_WEL = 1;
   localparam int STAT_WIP = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_STATUS,
      ST_IGNORE
   } spi_state_e;

   // Writes complete in a single cycle, so WIP never reads back as busy.
   function automatic logic [7:0] status_byte(input logic wel);
      logic [7:0] s;
      s           = 8'h00;
      s[STAT_WEL] = wel;
      s[STAT_WIP] = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Resetting to the pin's idle level avoids a false edge after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_cfg_responder.sv
// SPI mode-0 responder for the 25xx READ/WRITE/RDSR/WREN subset, oversampled
// by clk_dot4x and backed by a synchronous byte-wide memory port.
module spi_cfg_responder
   import spi_pkg::*;
#(
   parameter int         ADDR_WIDTH = 8,
   parameter logic [7:0] CMD_READ   = SPI_CMD_READ,
   parameter logic [7:0] CMD_WRITE  = SPI_CMD_WRITE,
   parameter logic [7:0] CMD_RDSR   = SPI_CMD_RDSR,
   parameter logic [7:0] CMD_WREN   = SPI_CMD_WREN
) (
   input  logic                  clk_dot4x,
   input  logic                  rst,
   input  logic                  spi_c,
   input  logic                  spi_d,
   input  logic                  spi_s,
   output logic                  spi_q,
   output logic                  spi_q_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [7:0]            mem_rdata,
   output logic                  wel
);

   localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
   localparam int ADDR_BITS  = ADDR_BYTES * 8;
   localparam int CNT_W      = $clog2(ADDR_BITS);
   localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_BITS - 1);

   logic c_rise, c_fall, unused_c_level;
   logic s_level, s_rise, s_fall;
   logic d_level, unused_d_rise, unused_d_fall;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_c (
      .clk_i(clk_dot4x), .rst_i(rst), .d_i(spi_c),
      .level_o(unused_c_level), .rise_o(c_rise), .fall_o(c_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_s (
      .clk_i(clk_dot4x), .rst_i(rst), .d_i(spi_s),
      .level_o(s_level), .rise_o(s_rise), .fall_o(s_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_d (
      .clk_i(clk_dot4x), .rst_i(rst), .d_i(spi_d),
      .level_o(d_level), .rise_o(unused_d_rise), .fall_o(unused_d_fall)
   );

   spi_state_e            state_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [ADDR_BITS-2:0]  shift_q;
   logic [7:0]            out_sr_q;
   logic                  spi_q_q;
   logic                  oe_q;
   logic                  is_read_q;
   logic                  wr_commit_q;
   logic                  wel_q;
   logic                  load_q;
   logic                  addr_inc_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [7:0]            mem_wdata_q;
   logic                  mem_we_q;
   logic                  mem_re_q;

   // Incoming word including the bit being sampled this cycle.
   logic [ADDR_BITS-1:0]  addr_full;
   logic [7:0]            byte_in;

   assign addr_full = {shift_q, d_level};
   assign byte_in   = {shift_q[6:0], d_level};

   always_ff @(posedge clk_dot4x or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         out_sr_q    <= 8'hFF;
         spi_q_q     <= 1'b1;
         oe_q        <= 1'b0;
         is_read_q   <= 1'b0;
         wr_commit_q <= 1'b0;
         wel_q       <= 1'b0;
         load_q      <= 1'b0;
         addr_inc_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
      end else begin
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
         addr_inc_q <= 1'b0;
         // Read data arrives the cycle after the strobe.
         load_q     <= mem_re_q;
         if (load_q)     out_sr_q   <= mem_rdata;
         if (addr_inc_q) mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);

         if (s_rise) begin
            state_q     <= ST_IDLE;
            spi_q_q     <= 1'b1;
            oe_q        <= 1'b0;
            wr_commit_q <= 1'b0;
            if (wr_commit_q) wel_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (s_fall) begin
                     state_q     <= ST_CMD;
                     bit_cnt_q   <= '0;
                     shift_q     <= '0;
                     wr_commit_q <= 1'b0;
                  end
               end
               ST_CMD: begin
                  if (c_rise) begin
                     shift_q   <= {shift_q[ADDR_BITS-3:0], d_level};
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     if (bit_cnt_q == CNT_BYTE_LAST) begin
                        bit_cnt_q <= '0;
                        if (byte_in == CMD_READ || byte_in == CMD_WRITE) begin
                           state_q   <= ST_ADDR;
                           is_read_q <= (byte_in == CMD_READ);
                        end else if (byte_in == CMD_RDSR) begin
                           state_q  <= ST_STATUS;
                           out_sr_q <= status_byte(wel_q);
                           oe_q     <= 1'b1;
                        end else if (byte_in == CMD_WREN) begin
                           state_q <= ST_IGNORE;
                           wel_q   <= 1'b1;
                        end else begin
                           state_q <= ST_IGNORE;
                        end
                     end
                  end
               end
               ST_ADDR: begin
                  if (c_rise) begin
                     shift_q   <= {shift_q[ADDR_BITS-3:0], d_level};
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     if (bit_cnt_q == CNT_ADDR_LAST) begin
                        bit_cnt_q  <= '0;
                        mem_addr_q <= addr_full[ADDR_WIDTH-1:0];
                        if (is_read_q) begin
                           state_q  <= ST_RD_DATA;
                           mem_re_q <= 1'b1;
                           oe_q     <= 1'b1;
                        end else begin
                           state_q <= ST_WR_DATA;
                        end
                     end
                  end
               end
               ST_RD_DATA: begin
                  if (c_fall) begin
                     spi_q_q   <= out_sr_q[7];
                     out_sr_q  <= {out_sr_q[6:0], 1'b1};
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     if (bit_cnt_q == CNT_BYTE_LAST) begin
                        bit_cnt_q  <= '0;
                        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                        mem_re_q   <= 1'b1;
                     end
                  end
               end
               ST_WR_DATA: begin
                  if (c_rise) begin
                     shift_q   <= {shift_q[ADDR_BITS-3:0], d_level};
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     if (bit_cnt_q == CNT_BYTE_LAST) begin
                        // Strobe at the current address; advance afterwards.
                        bit_cnt_q   <= '0;
                        mem_wdata_q <= byte_in;
                        addr_inc_q  <= 1'b1;
                        if (wel_q) begin
                           mem_we_q    <= 1'b1;
                           wr_commit_q <= 1'b1;
                        end
                     end
                  end
               end
               ST_STATUS: begin
                  if (c_fall) begin
                     spi_q_q   <= out_sr_q[7];
                     out_sr_q  <= {out_sr_q[6:0], 1'b1};
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     if (bit_cnt_q == CNT_BYTE_LAST) begin
                        bit_cnt_q <= '0;
                        out_sr_q  <= status_byte(wel_q);
                     end
                  end
               end
               ST_IGNORE: begin
                  spi_q_q <= 1'b1;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign spi_q     = spi_q_q;
   assign spi_q_oe  = oe_q & ~s_level;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign wel       = wel_q;

endmodule
